// File: rtl/game_flow_if.sv
// Game flow bus: control pulses from the input/debounce logic into the
// sequencer and the display fields from the sequencer out to the pixel generator.
interface game_flow_if;
    logic       start;
    logic       pause;
    logic       hit0;
    logic       hit1;
    logic       theme_btn;
    logic [3:0] state;
    logic [3:0] score0;
    logic [3:0] score1;
    logic [3:0] cnt0;
    logic [1:0] theme;

    // Upstream side: drives the pulses and observes the display fields.
    modport master (
        output start, pause, hit0, hit1, theme_btn,
        input  state, score0, score1, cnt0, theme
    );

    // Sequencer side.
    modport slave (
        input  start, pause, hit0, hit1, theme_btn,
        output state, score0, score1, cnt0, theme
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: game-level sequencer feeding the VGA pixel generator.
// Flow: idle -> blank -> countdown -> stage1..3 (with pause) -> win/lose -> finish.
// Optional feature: define THEME_CYCLE_EN to let theme_btn toggle the colour
// theme between 0 and 1; without it theme is tied to 0.
module game_flow_ctrl #(
    parameter int TICK_DIV   = 100000000,
    parameter int CNT_START  = 3,
    parameter int WIN_SCORE  = 9,
    parameter int STAGE2_PTS = 3,
    parameter int STAGE3_PTS = 6,
    parameter int HOLD_TICKS = 3
) (
    input  logic         clk,
    input  logic         rst,
    game_flow_if.slave   bus
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [TW-1:0] TCNT_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [3:0]    CNT_INIT  = 4'(CNT_START);
    localparam logic [3:0]    WIN_S     = 4'(WIN_SCORE);
    localparam logic [3:0]    STAGE2_S  = 4'(STAGE2_PTS);
    localparam logic [3:0]    STAGE3_S  = 4'(STAGE3_PTS);

    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_BRST   = 4'd1,
        ST_BPLAY  = 4'd2,
        ST_STAGE1 = 4'd3,
        ST_STAGE2 = 4'd4,
        ST_STAGE3 = 4'd5,
        ST_PMODE  = 4'd6,
        ST_WIN    = 4'd7,
        ST_LOSE   = 4'd8,
        ST_FINISH = 4'd9
    } state_e;

    state_e        state_q, state_d;
    state_e        saved_q, saved_d;
    logic [3:0]    score0_q, score0_d;
    logic [3:0]    score1_q, score1_d;
    logic [3:0]    cnt0_q, cnt0_d;
    logic [1:0]    theme_q, theme_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;

    logic          tick_s;
    logic [3:0]    score0_new_s;
    logic [3:0]    score1_new_s;

    // Score digit increment that sticks at 9 so the display never shows >9.
    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic en);
        if (en && (v < 4'd9)) begin
            return v + 4'd1;
        end else begin
            return v;
        end
    endfunction

    assign tick_s       = (tcnt_q == TCNT_LAST);
    assign score0_new_s = sat_inc(score0_q, bus.hit0);
    assign score1_new_s = sat_inc(score1_q, bus.hit1);

    // Next-state, score, countdown and phase-timer logic.
    always_comb begin
        state_d  = state_q;
        saved_d  = saved_q;
        score0_d = score0_q;
        score1_d = score1_q;
        cnt0_d   = cnt0_q;
        hcnt_d   = hcnt_q;
        tcnt_d   = tcnt_q;

        case (state_q)
            ST_RST: begin
                if (bus.start) begin
                    state_d  = ST_BRST;
                    score0_d = 4'd0;
                    score1_d = 4'd0;
                end else begin
                    state_d = ST_RST;
                end
            end
            ST_BRST: begin
                if (tick_s) begin
                    state_d = ST_BPLAY;
                    cnt0_d  = CNT_INIT;
                end else begin
                    state_d = ST_BRST;
                end
            end
            ST_BPLAY: begin
                if (!tick_s) begin
                    state_d = ST_BPLAY;
                end else if (cnt0_q > 4'd1) begin
                    cnt0_d = cnt0_q - 4'd1;
                end else begin
                    cnt0_d  = 4'd0;
                    state_d = ST_STAGE1;
                end
            end
            ST_STAGE1, ST_STAGE2, ST_STAGE3: begin
                // Pause wins over hits arriving in the same cycle; those hits are lost.
                if (bus.pause) begin
                    saved_d = state_q;
                    state_d = ST_PMODE;
                end else begin
                    score0_d = score0_new_s;
                    score1_d = score1_new_s;
                    if (score0_new_s == WIN_S) begin
                        state_d = ST_WIN;
                    end else if (score1_new_s == WIN_S) begin
                        state_d = ST_LOSE;
                    end else if ((state_q == ST_STAGE1) && (score0_new_s >= STAGE2_S)) begin
                        state_d = ST_STAGE2;
                    end else if ((state_q == ST_STAGE2) && (score0_new_s >= STAGE3_S)) begin
                        state_d = ST_STAGE3;
                    end else begin
                        state_d = state_q;
                    end
                end
            end
            ST_PMODE: begin
                if (bus.pause) begin
                    state_d = saved_q;
                end else begin
                    state_d = ST_PMODE;
                end
            end
            ST_WIN, ST_LOSE: begin
                if (!tick_s) begin
                    state_d = state_q;
                end else if (hcnt_q == HOLD_LAST) begin
                    state_d = ST_FINISH;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            ST_FINISH: begin
                if (bus.start) begin
                    state_d = ST_RST;
                end else begin
                    state_d = ST_FINISH;
                end
            end
            default: begin
                state_d = ST_RST;
            end
        endcase

        // Each phase is timed in whole ticks from its entry edge.
        if (state_d != state_q) begin
            tcnt_d = '0;
            hcnt_d = '0;
        end else if (tick_s) begin
            tcnt_d = '0;
        end else begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    // Colour theme selection.
    always_comb begin
`ifdef THEME_CYCLE_EN
        theme_d = {1'b0, theme_q[0] ^ bus.theme_btn};
`else
        theme_d = 2'b00;
`endif
    end

`ifndef THEME_CYCLE_EN
    logic unused_theme_btn_s;
    assign unused_theme_btn_s = bus.theme_btn;
`endif

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RST;
            saved_q  <= ST_STAGE1;
            score0_q <= 4'd0;
            score1_q <= 4'd0;
            cnt0_q   <= 4'd0;
            theme_q  <= 2'b00;
            tcnt_q   <= '0;
            hcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            saved_q  <= saved_d;
            score0_q <= score0_d;
            score1_q <= score1_d;
            cnt0_q   <= cnt0_d;
            theme_q  <= theme_d;
            tcnt_q   <= tcnt_d;
            hcnt_q   <= hcnt_d;
        end
    end

    assign bus.state  = state_q;
    assign bus.score0 = score0_q;
    assign bus.score1 = score1_q;
    assign bus.cnt0   = cnt0_q;
    assign bus.theme  = theme_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: a vector table for the main flow,
// hand-written corner sequences, then random pulses against a reference model.
module tb_game_flow_ctrl;

    localparam int TD = 4;
    localparam int CS = 3;
    localparam int WS = 9;
    localparam int S2 = 3;
    localparam int S3 = 6;
    localparam int HT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    game_flow_if bus();

    game_flow_ctrl #(
        .TICK_DIV  (TD),
        .CNT_START (CS),
        .WIN_SCORE (WS),
        .STAGE2_PTS(S2),
        .STAGE3_PTS(S3),
        .HOLD_TICKS(HT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic       r, st, pa, h0, h1;
        int         idle;
        logic [3:0] es, e0, e1, ec;
    } vec_t;

    vec_t tbl[$];

    // Reference model state (plain integers, time measured in cycles).
    int m_state, m_s0, m_s1, m_cnt, m_theme, m_saved, m_cyc;

    task automatic add(input logic r, st, pa, h0, h1, input int idle,
                       input logic [3:0] es, e0, e1, ec);
        vec_t v;
        v.r = r; v.st = st; v.pa = pa; v.h0 = h0; v.h1 = h1; v.idle = idle;
        v.es = es; v.e0 = e0; v.e1 = e1; v.ec = ec;
        tbl.push_back(v);
    endtask

    // Drive one cycle of inputs, let one rising edge pass, sample 1 time unit later.
    task automatic step(input logic r, st, pa, h0, h1, tb_);
        rst = r; bus.start = st; bus.pause = pa; bus.hit0 = h0; bus.hit1 = h1; bus.theme_btn = tb_;
        @(posedge clk);
        #1;
        rst = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
        bus.hit0 = 1'b0; bus.hit1 = 1'b0; bus.theme_btn = 1'b0;
    endtask

    task automatic check(input string nm, input logic [3:0] es, e0, e1, ec, input logic [1:0] eth);
        vectors++;
        if ({bus.state, bus.score0, bus.score1, bus.cnt0, bus.theme} !== {es, e0, e1, ec, eth}) begin
            miscompares++;
            $display("FAIL %s: got state=%0d s0=%0d s1=%0d cnt0=%0d theme=%0d, want state=%0d s0=%0d s1=%0d cnt0=%0d theme=%0d",
                     nm, bus.state, bus.score0, bus.score1, bus.cnt0, bus.theme, es, e0, e1, ec, eth);
        end
    endtask

    task automatic go_stage1();
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        repeat (TD * (CS + 1)) step(0, 0, 0, 0, 0, 0);
        check("enter_stage1", 4'd3, 4'd0, 4'd0, 4'd0, 2'd0);
    endtask

    task automatic model_reset();
        m_state = 0; m_s0 = 0; m_s1 = 0; m_cnt = 0; m_theme = 0; m_saved = 3; m_cyc = 0;
    endtask

    // One clock edge of the game rules; phase timing from cycles since entry.
    task automatic model_step(input logic r, st, pa, h0, h1, tb_);
        int n;
        int nxt;
        if (r) begin
            model_reset();
            return;
        end
`ifdef THEME_CYCLE_EN
        m_theme = (m_theme + int'(tb_)) % 2;
`else
        if (tb_) m_theme = 0;
`endif
        n   = m_cyc + 1;
        nxt = m_state;
        case (m_state)
            0: if (st) begin nxt = 1; m_s0 = 0; m_s1 = 0; end
            1: if (n == TD) begin nxt = 2; m_cnt = CS; end
            2: begin
                if (n == CS * TD) begin nxt = 3; m_cnt = 0; end
                else m_cnt = CS - n / TD;
            end
            3, 4, 5: begin
                if (pa) begin
                    m_saved = m_state;
                    nxt = 6;
                end else begin
                    if (h0 && m_s0 < 9) m_s0++;
                    if (h1 && m_s1 < 9) m_s1++;
                    if (m_s0 == WS)                    nxt = 7;
                    else if (m_s1 == WS)               nxt = 8;
                    else if (m_state == 3 && m_s0 >= S2) nxt = 4;
                    else if (m_state == 4 && m_s0 >= S3) nxt = 5;
                end
            end
            6: if (pa) nxt = m_saved;
            7, 8: if (n == HT * TD) nxt = 9;
            9: if (st) nxt = 0;
            default: nxt = 0;
        endcase
        m_cyc   = (nxt != m_state) ? 0 : n;
        m_state = nxt;
    endtask

    logic [1:0] th1;

    initial begin
        bus.start = 1'b0; bus.pause = 1'b0; bus.hit0 = 1'b0;
        bus.hit1 = 1'b0; bus.theme_btn = 1'b0;
        rst = 1'b1;
`ifdef THEME_CYCLE_EN
        th1 = 2'd1;
`else
        th1 = 2'd0;
`endif

        // ---- main flow table (TICK_DIV=4, CNT_START=3, HOLD_TICKS=3) ----
        add(1,0,0,0,0, 0, 4'd0, 4'd0, 4'd0, 4'd0);
        add(1,0,0,0,0, 0, 4'd0, 4'd0, 4'd0, 4'd0);
        add(0,1,0,0,0, 0, 4'd1, 4'd0, 4'd0, 4'd0);
        add(0,0,0,0,0, 2, 4'd1, 4'd0, 4'd0, 4'd0);
        add(0,0,0,0,0, 0, 4'd2, 4'd0, 4'd0, 4'd3);
        add(0,0,0,0,0, 2, 4'd2, 4'd0, 4'd0, 4'd3);
        add(0,0,0,0,0, 0, 4'd2, 4'd0, 4'd0, 4'd2);
        add(0,0,0,0,0, 3, 4'd2, 4'd0, 4'd0, 4'd1);
        add(0,0,0,0,0, 3, 4'd3, 4'd0, 4'd0, 4'd0);
        add(0,0,0,1,0, 0, 4'd3, 4'd1, 4'd0, 4'd0);
        add(0,0,0,1,0, 0, 4'd3, 4'd2, 4'd0, 4'd0);
        add(0,0,0,1,0, 0, 4'd4, 4'd3, 4'd0, 4'd0);
        add(0,1,0,0,0, 0, 4'd4, 4'd3, 4'd0, 4'd0);
        add(0,0,0,1,0, 0, 4'd4, 4'd4, 4'd0, 4'd0);
        add(0,0,0,1,0, 0, 4'd4, 4'd5, 4'd0, 4'd0);
        add(0,0,0,1,0, 0, 4'd5, 4'd6, 4'd0, 4'd0);
        add(0,0,0,0,1, 0, 4'd5, 4'd6, 4'd1, 4'd0);
        add(0,0,0,1,0, 0, 4'd5, 4'd7, 4'd1, 4'd0);
        add(0,0,0,1,0, 0, 4'd5, 4'd8, 4'd1, 4'd0);
        add(0,0,0,1,0, 0, 4'd7, 4'd9, 4'd1, 4'd0);
        add(0,0,0,0,0, 10, 4'd7, 4'd9, 4'd1, 4'd0);
        add(0,0,0,0,0, 0, 4'd9, 4'd9, 4'd1, 4'd0);
        add(0,0,0,1,0, 0, 4'd9, 4'd9, 4'd1, 4'd0);
        add(0,1,0,0,0, 0, 4'd0, 4'd9, 4'd1, 4'd0);
        add(0,1,0,0,0, 0, 4'd1, 4'd0, 4'd0, 4'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].st, tbl[i].pa, tbl[i].h0, tbl[i].h1, 1'b0);
            for (int k = 0; k < tbl[i].idle; k++) step(0, 0, 0, 0, 0, 0);
            check($sformatf("table[%0d]", i), tbl[i].es, tbl[i].e0, tbl[i].e1, tbl[i].ec, 2'd0);
        end

        // ---- simultaneous final hits: win outranks lose ----
        go_stage1();
        repeat (8) step(0, 0, 0, 0, 1, 0);
        check("s1_at_8", 4'd3, 4'd0, 4'd8, 4'd0, 2'd0);
        repeat (8) step(0, 0, 0, 1, 0, 0);
        check("both_at_8", 4'd5, 4'd8, 4'd8, 4'd0, 2'd0);
        step(0, 0, 0, 1, 1, 0);
        check("dual_hit_win", 4'd7, 4'd9, 4'd9, 4'd0, 2'd0);

        // ---- pause drops coincident hit, pmode ignores hits, resume to stage2 ----
        go_stage1();
        repeat (3) step(0, 0, 0, 1, 0, 0);
        check("reach_stage2", 4'd4, 4'd3, 4'd0, 4'd0, 2'd0);
        step(0, 0, 1, 1, 0, 0);
        check("pause_with_hit", 4'd6, 4'd3, 4'd0, 4'd0, 2'd0);
        step(0, 0, 0, 0, 1, 0);
        check("pmode_hit_ignored", 4'd6, 4'd3, 4'd0, 4'd0, 2'd0);
        step(0, 0, 1, 0, 0, 0);
        check("resume_stage2", 4'd4, 4'd3, 4'd0, 4'd0, 2'd0);

        // ---- start ignored in a stage; reset honoured mid-game ----
        go_stage1();
        step(0, 1, 0, 0, 0, 0);
        check("start_ignored", 4'd3, 4'd0, 4'd0, 4'd0, 2'd0);
        repeat (6) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check("reach_stage3", 4'd5, 4'd6, 4'd1, 4'd0, 2'd0);
        step(1, 0, 0, 0, 0, 0);
        check("rst_mid_game", 4'd0, 4'd0, 4'd0, 4'd0, 2'd0);

        // ---- theme button ----
        step(0, 0, 0, 0, 0, 1);
        check("theme_press1", 4'd0, 4'd0, 4'd0, 4'd0, th1);
        step(0, 0, 0, 0, 0, 1);
        check("theme_press2", 4'd0, 4'd0, 4'd0, 4'd0, 2'd0);

        // ---- random pulses against the reference model ----
        step(1, 0, 0, 0, 0, 0);
        model_reset();
        check("rand_reset", 4'(m_state), 4'(m_s0), 4'(m_s1), 4'(m_cnt), 2'(m_theme));
        for (int c = 0; c < 3000; c++) begin
            logic r, st, pa, h0, h1, tb_;
            r   = ($urandom_range(0, 399) == 0);
            st  = ($urandom_range(0, 7)   == 0);
            pa  = ($urandom_range(0, 19)  == 0);
            h0  = ($urandom_range(0, 3)   == 0);
            h1  = ($urandom_range(0, 4)   == 0);
            tb_ = ($urandom_range(0, 9)   == 0);
            step(r, st, pa, h0, h1, tb_);
            model_step(r, st, pa, h0, h1, tb_);
            check($sformatf("random[%0d]", c), 4'(m_state), 4'(m_s0), 4'(m_s1), 4'(m_cnt), 2'(m_theme));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
